rom_loader: RTL and testbench

- Boot-time program loader sitting directly upstream of the instruction ROM.
- Accepts a framed byte stream from the host link (UART receiver) over a valid/ready handshake.
- Assembles little-endian 32-bit instruction words and drives the ROM write port (w_rom_data, w_rom_addr, en_w_rom).
- Holds the core in load state via load_busy_o until the frame is written and its checksum verified.

---
 rtl/rom_loader.sv | 124 ++++++++++++
 tb/tb_rom_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// Boot-time program loader: turns a framed byte stream into little-endian 32-bit ROM writes.
// Latency: a word is written in the cycle after its fourth byte is accepted; status follows the checksum byte.
// Backpressure: byte_ready_o drops in IDLE/WRITE/DONE/ERR, so the sender stalls during each ROM write.
module rom_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic [31:0] w_rom_data,
  output logic [15:0] w_rom_addr,
  output logic        en_w_rom,
  output logic        load_busy_o,
  output logic        load_done_o,
  output logic        load_err_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR0  = 3'd1;
  localparam logic [2:0] S_HDR1  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;
  localparam logic [2:0] S_CSUM  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;
  localparam logic [2:0] S_ERR   = 3'd7;

  logic [2:0]  state;
  logic [7:0]  cnt_lo;
  logic [15:0] n_words;
  logic [15:0] idx;
  logic [1:0]  lane;
  logic [7:0]  csum;
  logic [23:0] shadow;
  logic        accept;
  logic [16:0] n_hdr;
  logic        more_words;

  // All status outputs decode straight from the state, so reset clears them asynchronously.
  assign byte_ready_o = (state == S_HDR0) || (state == S_HDR1) ||
                        (state == S_DATA) || (state == S_CSUM);
  assign en_w_rom     = (state == S_WRITE);
  assign load_busy_o  = byte_ready_o || en_w_rom;
  assign load_done_o  = (state == S_DONE);
  assign load_err_o   = (state == S_ERR);

  assign accept     = byte_valid_i && byte_ready_o;
  assign n_hdr      = {1'b0, byte_i, cnt_lo};
  // 17-bit compare so idx+1 never wraps against the word count.
  assign more_words = ({1'b0, idx} + 17'd1) < {1'b0, n_words};

  // Frame parser, word assembler and ROM write-port registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      cnt_lo     <= 8'h00;
      n_words    <= 16'h0000;
      idx        <= 16'h0000;
      lane       <= 2'd0;
      csum       <= 8'h00;
      shadow     <= 24'h000000;
      w_rom_data <= 32'h00000000;
      w_rom_addr <= BASE_ADDR;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            state <= S_HDR0;
            idx   <= 16'h0000;
            lane  <= 2'd0;
            csum  <= 8'h00;
          end
        end
        S_HDR0: begin
          if (accept) begin
            cnt_lo <= byte_i;
            state  <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (accept) begin
            n_words <= n_hdr[15:0];
            if (n_hdr == 17'd0)
              state <= S_CSUM;
            else if (n_hdr > 17'(MAX_WORDS))
              state <= S_ERR;
            else
              state <= S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            csum <= csum ^ byte_i;
            lane <= lane + 2'd1;
            case (lane)
              2'd0: shadow[7:0]   <= byte_i;
              2'd1: shadow[15:8]  <= byte_i;
              2'd2: shadow[23:16] <= byte_i;
              default: begin
                // Word and address are captured together so they stay valid after the write.
                w_rom_data <= {byte_i, shadow};
                w_rom_addr <= BASE_ADDR + idx;
                state      <= S_WRITE;
              end
            endcase
          end
        end
        S_WRITE: begin
          idx   <= idx + 16'd1;
          state <= more_words ? S_DATA : S_CSUM;
        end
        S_CSUM: begin
          if (accept)
            state <= (byte_i == csum) ? S_DONE : S_ERR;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Randomised self-checking bench for rom_loader against a frame-level reference model.
// Each scenario task drives one or more frames and compares writes and final status.
// The model parses whole frames; the driver applies random valid gaps.
module tb_rom_loader;

  localparam logic [15:0] BASE = 16'h0000;
  localparam int          MAXW = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  byte_d;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] w_rom_data;
  logic [15:0] w_rom_addr;
  logic        en_w_rom;
  logic        busy;
  logic        done;
  logic        err;

  rom_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .byte_i(byte_d),
    .byte_valid_i(byte_valid), .byte_ready_o(byte_ready),
    .w_rom_data(w_rom_data), .w_rom_addr(w_rom_addr), .en_w_rom(en_w_rom),
    .load_busy_o(busy), .load_done_o(done), .load_err_o(err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [47:0] wr_q[$];   // observed writes {addr, data}
  logic [47:0] exp_q[$];  // expected writes {addr, data}
  int          exp_consumed;
  bit          exp_done;
  bit          exp_err;

  // Record every ROM write; the loader must not be taking bytes in that cycle.
  always @(negedge clk) begin
    if (en_w_rom === 1'b1) begin
      wr_q.push_back({w_rom_addr, w_rom_data});
      n_chk++;
      if (byte_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_in_write: byte_ready=%b required 0", byte_ready);
      end
    end
  end

  // Frame-level reference: word count, little-endian words, XOR checksum.
  task automatic model_frame(input logic [7:0] fb[$]);
    int          n;
    logic [7:0]  x;
    logic [31:0] word;
    exp_q.delete();
    exp_done = 0;
    exp_err  = 0;
    n = int'({fb[1], fb[0]});
    if (n > MAXW) begin
      exp_err      = 1;
      exp_consumed = 2;
      return;
    end
    x = 8'h00;
    for (int w = 0; w < n; w++) begin
      word = {fb[2+4*w+3], fb[2+4*w+2], fb[2+4*w+1], fb[2+4*w]};
      exp_q.push_back({16'(int'(BASE) + w), word});
      for (int b = 0; b < 4; b++) x = x ^ fb[2+4*w+b];
    end
    exp_consumed = 2 + 4*n + 1;
    if (fb[2+4*n] == x) exp_done = 1;
    else                exp_err  = 1;
  endtask

  // Start a load (start and the first byte presented together) and stream the frame.
  // stop_after >= 0 ends the stream early without final checks.
  task automatic run_frame(input string name, input logic [7:0] fb[$],
                           input int gap_pct, input int stop_after);
    int idx;
    int cycles;
    int limit;
    model_frame(fb);
    limit = (stop_after >= 0) ? stop_after : exp_consumed;
    wr_q.delete();
    @(negedge clk);
    start      = 1'b1;
    byte_valid = 1'b1;
    byte_d     = fb[0];
    n_chk++;
    if (byte_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s start_cycle_ready: got %b required 0", name, byte_ready);
    end
    @(negedge clk);
    start  = 1'b0;
    idx    = 0;
    cycles = 0;
    while (idx < limit && cycles < 2000) begin
      if ($urandom_range(99) < gap_pct) begin
        byte_valid = 1'b0;
        byte_d     = 8'($urandom);
      end else begin
        byte_valid = 1'b1;
        byte_d     = fb[idx];
        if (byte_ready === 1'b1) idx++;
      end
      @(negedge clk);
      cycles++;
    end
    byte_valid = 1'b0;
    if (idx < limit) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s timeout: accepted %0d bytes required %0d", name, idx, limit);
      return;
    end
    if (stop_after >= 0) return;
    // Bytes beyond the frame must not be taken.
    if (idx < fb.size()) begin
      for (int k = 0; k < 5; k++) begin
        byte_valid = 1'b1;
        byte_d     = fb[idx];
        n_chk++;
        if (byte_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL %s extra_byte_ready: got %b required 0", name, byte_ready);
        end
        @(negedge clk);
      end
      byte_valid = 1'b0;
    end
    n_chk++;
    if ({done, err, busy} !== {exp_done, exp_err, 1'b0}) begin
      n_fail++;
      $display("FAIL %s status: done/err/busy=%b%b%b required %b%b0",
               name, done, err, busy, exp_done, exp_err);
    end
    n_chk++;
    if (wr_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d required %0d", name, wr_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_chk++;
        if (wr_q[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL %s write%0d: addr/data=%h/%h required %h/%h", name, i,
                   wr_q[i][47:32], wr_q[i][31:0], exp_q[i][47:32], exp_q[i][31:0]);
        end
      end
    end
  endtask

  task automatic check_reset_values(input string name);
    n_chk++;
    if ({byte_ready, en_w_rom, w_rom_data, w_rom_addr, busy, done, err} !==
        {1'b0, 1'b0, 32'h0, BASE, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL %s reset_values: rdy=%b en=%b data=%h addr=%h busy=%b done=%b err=%b required all zero, addr=%h",
               name, byte_ready, en_w_rom, w_rom_data, w_rom_addr, busy, done, err, BASE);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    check_reset_values("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("after_release");
  endtask

  task automatic test_basic();
    logic [7:0] f[$];
    // Checksum byte is the XOR of the eight data bytes: 13^93^10 = 90.
    f = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    run_frame("basic", f, 0, -1);
    n_chk++;
    if ({w_rom_addr, w_rom_data} !== {BASE + 16'd1, 32'h00100093}) begin
      n_fail++;
      $display("FAIL basic_hold: addr/data=%h/%h required %h/00100093", w_rom_addr, w_rom_data, BASE + 16'd1);
    end
  endtask

  task automatic test_bad_csum();
    logic [7:0] f[$];
    f = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h81};
    run_frame("bad_csum", f, 0, -1);
  endtask

  task automatic test_len_err();
    logic [7:0] f[$];
    f = '{8'h01, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
    run_frame("len_err", f, 0, -1);
  endtask

  task automatic test_zero_words();
    logic [7:0] f[$];
    f = '{8'h00, 8'h00, 8'h00};
    run_frame("zero_ok", f, 0, -1);
    f = '{8'h00, 8'h00, 8'h5A};
    run_frame("zero_bad", f, 0, -1);
  endtask

  task automatic test_gaps();
    logic [7:0] f[$];
    f = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    run_frame("gaps", f, 50, -1);
  endtask

  task automatic test_mid_reset();
    logic [7:0] f[$];
    f = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    run_frame("mid_reset", f, 0, 8);
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("mid_reset");
    n_chk++;
    if (wr_q.size() != 1 || wr_q[0] !== {BASE, 32'h00000013}) begin
      n_fail++;
      $display("FAIL mid_reset_writes: count=%0d required 1 with %h/00000013", wr_q.size(), BASE);
    end
    @(negedge clk);
    rst = 1'b0;
    run_frame("after_mid_reset", f, 0, -1);
  endtask

  task automatic test_random();
    logic [7:0] f[$];
    logic [7:0] x;
    int         n;
    for (int t = 0; t < 8; t++) begin
      f.delete();
      n = $urandom_range(1, 5);
      f.push_back(8'(n));
      f.push_back(8'h00);
      x = 8'h00;
      for (int b = 0; b < 4*n; b++) begin
        f.push_back(8'($urandom));
        x = x ^ f[f.size()-1];
      end
      if ($urandom_range(3) == 0) x = x ^ 8'($urandom_range(1, 255));
      f.push_back(x);
      run_frame($sformatf("random%0d", t), f, $urandom_range(0, 60), -1);
    end
  endtask

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_d     = 8'h00;
    test_reset();
    test_basic();
    test_bad_csum();
    test_len_err();
    test_zero_words();
    test_gaps();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
